// File: rtl/aes_controller_input_stage.sv
// AES controller input stage: latches the packet command word, packs the following
// 32-bit bus words big-endian into 128-bit blocks and queues {tlast, block} in a FWFT FIFO.
module aes_controller_input_stage #(
  parameter int BUS_DATA_WIDTH  = 32,
  parameter int FIFO_DATA_WIDTH = 129,
  parameter int FIFO_ADDR_WIDTH = 8,
  parameter int FIFO_SIZE       = 256
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       bus_data_wren,
  input  logic                       bus_tlast,
  input  logic [BUS_DATA_WIDTH-1:0]  bus_data,
  output logic                       in_fifo_read_tvalid,
  input  logic                       in_fifo_read_tready,
  output logic [FIFO_DATA_WIDTH-1:0] in_fifo_rdata,
  output logic                       in_fifo_empty,
  output logic                       controller_in_done,
  output logic                       controller_in_busy,
  output logic [31:0]                aes_cmd
);

  localparam int CNT_W   = FIFO_ADDR_WIDTH + 1;
  localparam int BLOCK_W = 128;

  typedef enum logic {
    ST_CMD  = 1'b0,
    ST_DATA = 1'b1
  } state_e;

  state_e                     state_q, state_d;
  logic [31:0]                aes_cmd_q, aes_cmd_d;
  logic                       done_q, done_d;
  logic [1:0]                 word_idx_q, word_idx_d;
  logic [BLOCK_W-33:0]        pack_q, pack_d;
  logic [FIFO_ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]           count_q, count_d;
  logic [FIFO_DATA_WIDTH-1:0] mem_q [FIFO_SIZE];

  logic               fifo_full;
  logic               word_accept;
  logic               fifo_push;
  logic               fifo_pop;
  logic               push_en;
  logic [BLOCK_W-1:0] block_w;

  assign fifo_full           = (count_q == CNT_W'(FIFO_SIZE));
  assign in_fifo_empty       = (count_q == '0);
  assign in_fifo_read_tvalid = !in_fifo_empty;
  assign in_fifo_rdata       = mem_q[rd_ptr_q];
  assign controller_in_busy  = fifo_full;
  assign controller_in_done  = done_q;
  assign aes_cmd             = aes_cmd_q;

  assign word_accept = bus_data_wren && !controller_in_busy;
  assign fifo_pop    = in_fifo_read_tready && !in_fifo_empty;
  // A pop frees the slot the push lands in, so push+pop at full is legal.
  assign push_en     = fifo_push && (!fifo_full || fifo_pop);

  // ---------------------------------------------------------------------------
  // FSM: state register
  // NOTE: sequential state uses non-blocking assignments only; comb blocks use blocking.
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_CMD;
    else       state_q <= state_d;
  end

  // FSM: next-state logic
  always_comb begin
    state_d = state_q;
    if (word_accept) begin
      unique case (state_q)
        ST_CMD:  if (!bus_tlast) state_d = ST_DATA;
        ST_DATA: if (bus_tlast)  state_d = ST_CMD;
        default: state_d = ST_CMD;
      endcase
    end
  end

  // FSM: outputs and datapath next-state
  // NOTE: every signal gets a default at the top so no path can infer a latch.
  always_comb begin
    aes_cmd_d  = aes_cmd_q;
    done_d     = done_q;
    word_idx_d = word_idx_q;
    pack_d     = pack_q;
    fifo_push  = 1'b0;
    block_w    = {pack_q, 32'h0};

    unique case (word_idx_q)
      2'd0:    block_w[127:96] = bus_data;
      2'd1:    block_w[95:64]  = bus_data;
      2'd2:    block_w[63:32]  = bus_data;
      default: block_w[31:0]   = bus_data;
    endcase

    if (word_accept) begin
      unique case (state_q)
        ST_CMD: begin
          aes_cmd_d = bus_data;
          // A command with tlast carries no data: the packet is already complete.
          done_d    = bus_tlast;
        end
        ST_DATA: begin
          if (word_idx_q == 2'd3 || bus_tlast) begin
            // Pack register is cleared here, so unfilled low words read as zero padding.
            fifo_push  = 1'b1;
            pack_d     = '0;
            word_idx_d = 2'd0;
            if (bus_tlast) done_d = 1'b1;
          end else begin
            pack_d     = block_w[BLOCK_W-1:32];
            word_idx_d = word_idx_q + 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // FIFO pointer and occupancy next-state
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_en)
      wr_ptr_d = (wr_ptr_q == FIFO_ADDR_WIDTH'(FIFO_SIZE - 1)) ? '0 : wr_ptr_q + 1'b1;
    if (fifo_pop)
      rd_ptr_d = (rd_ptr_q == FIFO_ADDR_WIDTH'(FIFO_SIZE - 1)) ? '0 : rd_ptr_q + 1'b1;
    unique case ({push_en, fifo_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      aes_cmd_q  <= '0;
      done_q     <= 1'b0;
      word_idx_q <= '0;
      pack_q     <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      aes_cmd_q  <= aes_cmd_d;
      done_q     <= done_d;
      word_idx_q <= word_idx_d;
      pack_q     <= pack_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  // NOTE: storage is not reset; zero occupancy already marks every entry invalid.
  always_ff @(posedge clk) begin
    if (push_en) mem_q[wr_ptr_q] <= {bus_tlast, block_w};
  end

endmodule

// File: tb/tb_aes_controller_input_stage.sv
// Directed self-checking bench for aes_controller_input_stage: packing, tlast padding,
// FIFO ordering, full/busy handling and mid-packet reset.
module tb_aes_controller_input_stage;

  logic         clk = 1'b0;
  logic         reset;
  logic         bus_data_wren;
  logic         bus_tlast;
  logic [31:0]  bus_data;
  logic         in_fifo_read_tvalid;
  logic         in_fifo_read_tready;
  logic [128:0] in_fifo_rdata;
  logic         in_fifo_empty;
  logic         controller_in_done;
  logic         controller_in_busy;
  logic [31:0]  aes_cmd;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  aes_controller_input_stage dut (
    .clk                 (clk),
    .reset               (reset),
    .bus_data_wren       (bus_data_wren),
    .bus_tlast           (bus_tlast),
    .bus_data            (bus_data),
    .in_fifo_read_tvalid (in_fifo_read_tvalid),
    .in_fifo_read_tready (in_fifo_read_tready),
    .in_fifo_rdata       (in_fifo_rdata),
    .in_fifo_empty       (in_fifo_empty),
    .controller_in_done  (controller_in_done),
    .controller_in_busy  (controller_in_busy),
    .aes_cmd             (aes_cmd)
  );

  // Word j of fill-block k in the full-FIFO scenario.
  function automatic logic [31:0] fill_word(input int k, input int j);
    return 32'hC000_0000 | (32'(k) << 8) | 32'(j);
  endfunction

  function automatic logic [128:0] fill_entry(input int k);
    return {1'b0, fill_word(k, 0), fill_word(k, 1), fill_word(k, 2), fill_word(k, 3)};
  endfunction

  // One bus word, optionally with a simultaneous consumer pop on the same edge.
  task automatic send_word(input logic [31:0] d, input logic last, input logic pop);
    @(negedge clk);
    bus_data_wren       = 1'b1;
    bus_data            = d;
    bus_tlast           = last;
    in_fifo_read_tready = pop;
    @(posedge clk);
    #1;
    bus_data_wren       = 1'b0;
    bus_tlast           = 1'b0;
    in_fifo_read_tready = 1'b0;
  endtask

  task automatic pop_one();
    @(negedge clk);
    in_fifo_read_tready = 1'b1;
    @(posedge clk);
    #1;
    in_fifo_read_tready = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    repeat (2) @(negedge clk);
    checks++; if (in_fifo_read_tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid got=%b want=0", in_fifo_read_tvalid); end
    checks++; if (in_fifo_empty !== 1'b1) begin errors++; $display("FAIL reset_empty got=%b want=1", in_fifo_empty); end
    checks++; if (controller_in_done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b want=0", controller_in_done); end
    checks++; if (controller_in_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", controller_in_busy); end
    checks++; if (aes_cmd !== 32'h0) begin errors++; $display("FAIL reset_cmd got=%h want=0", aes_cmd); end
    // tready while empty must not disturb the FIFO
    pop_one();
    @(negedge clk);
    checks++; if (in_fifo_empty !== 1'b1) begin errors++; $display("FAIL empty_pop got=%b want=1", in_fifo_empty); end
  endtask

  task automatic test_single_block();
    logic [128:0] exp;
    exp = {1'b1, 128'h00112233_44556677_8899AABB_CCDDEEFF};
    send_word(32'h0000_0025, 1'b0, 1'b0);
    @(negedge clk);
    checks++; if (aes_cmd !== 32'h0000_0025) begin errors++; $display("FAIL single_cmd got=%h want=00000025", aes_cmd); end
    checks++; if (in_fifo_empty !== 1'b1) begin errors++; $display("FAIL cmd_not_pushed got=%b want=1", in_fifo_empty); end
    send_word(32'h0011_2233, 1'b0, 1'b0);
    send_word(32'h4455_6677, 1'b0, 1'b0);
    send_word(32'h8899_AABB, 1'b0, 1'b0);
    send_word(32'hCCDD_EEFF, 1'b1, 1'b0);
    @(negedge clk);
    checks++; if (controller_in_done !== 1'b1) begin errors++; $display("FAIL single_done got=%b want=1", controller_in_done); end
    checks++; if (in_fifo_read_tvalid !== 1'b1) begin errors++; $display("FAIL single_tvalid got=%b want=1", in_fifo_read_tvalid); end
    checks++; if (in_fifo_rdata !== exp) begin errors++; $display("FAIL single_entry got=%h want=%h", in_fifo_rdata, exp); end
    pop_one();
    @(negedge clk);
    checks++; if (in_fifo_empty !== 1'b1) begin errors++; $display("FAIL single_drain got=%b want=1", in_fifo_empty); end
  endtask

  task automatic test_back_to_back();
    logic [128:0] exp0, exp1;
    exp0 = {1'b0, 128'h11110000_11110001_11110002_11110003};
    exp1 = {1'b1, 128'h11110004_11110005_11110006_11110007};
    send_word(32'h0000_0031, 1'b0, 1'b0);
    @(negedge clk);
    checks++; if (controller_in_done !== 1'b0) begin errors++; $display("FAIL cmd_clears_done got=%b want=0", controller_in_done); end
    checks++; if (aes_cmd !== 32'h0000_0031) begin errors++; $display("FAIL b2b_cmd got=%h want=00000031", aes_cmd); end
    for (int i = 0; i < 8; i++) send_word(32'h1111_0000 + 32'(i), (i == 7), 1'b0);
    @(negedge clk);
    checks++; if (in_fifo_rdata !== exp0) begin errors++; $display("FAIL b2b_entry0 got=%h want=%h", in_fifo_rdata, exp0); end
    pop_one();
    @(negedge clk);
    checks++; if (in_fifo_rdata !== exp1) begin errors++; $display("FAIL b2b_entry1 got=%h want=%h", in_fifo_rdata, exp1); end
    pop_one();
    @(negedge clk);
    checks++; if (in_fifo_empty !== 1'b1) begin errors++; $display("FAIL b2b_drain got=%b want=1", in_fifo_empty); end
    checks++; if (controller_in_done !== 1'b1) begin errors++; $display("FAIL b2b_done got=%b want=1", controller_in_done); end
  endtask

  task automatic test_partial_block();
    logic [128:0] exp;
    exp = {1'b1, 128'hAAAAAAAA_BBBBBBBB_00000000_00000000};
    send_word(32'h0000_0042, 1'b0, 1'b0);
    send_word(32'hAAAA_AAAA, 1'b0, 1'b0);
    send_word(32'hBBBB_BBBB, 1'b1, 1'b0);
    @(negedge clk);
    checks++; if (in_fifo_rdata !== exp) begin errors++; $display("FAIL partial_entry got=%h want=%h", in_fifo_rdata, exp); end
    pop_one();
    // Command with tlast: packet with no data
    send_word(32'h0000_0063, 1'b1, 1'b0);
    @(negedge clk);
    checks++; if (in_fifo_empty !== 1'b1) begin errors++; $display("FAIL cmd_only_empty got=%b want=1", in_fifo_empty); end
    checks++; if (controller_in_done !== 1'b1) begin errors++; $display("FAIL cmd_only_done got=%b want=1", controller_in_done); end
    checks++; if (aes_cmd !== 32'h0000_0063) begin errors++; $display("FAIL cmd_only_cmd got=%h want=00000063", aes_cmd); end
  endtask

  task automatic test_full();
    logic [128:0] exp_a, exp_b;
    exp_a = {1'b0, 128'hA0000000_A0000001_A0000002_A0000003};
    exp_b = {1'b1, 128'hB0000000_B0000001_B0000002_B0000003};
    send_word(32'h0000_0077, 1'b0, 1'b0);
    for (int k = 0; k < 256; k++)
      for (int j = 0; j < 4; j++) send_word(fill_word(k, j), 1'b0, 1'b0);
    @(negedge clk);
    checks++; if (controller_in_busy !== 1'b1) begin errors++; $display("FAIL full_busy got=%b want=1", controller_in_busy); end
    // Ignored while busy; would shift packing of the next block if accepted
    send_word(32'hDEAD_BEEF, 1'b0, 1'b0);
    @(negedge clk);
    checks++; if (in_fifo_rdata !== fill_entry(0)) begin errors++; $display("FAIL full_head got=%h want=%h", in_fifo_rdata, fill_entry(0)); end
    pop_one();
    @(negedge clk);
    checks++; if (controller_in_busy !== 1'b0) begin errors++; $display("FAIL busy_drop got=%b want=0", controller_in_busy); end
    // Last word of block A pushes while block 1 pops: occupancy stays at 255
    for (int j = 0; j < 4; j++) send_word(32'hA000_0000 + 32'(j), 1'b0, (j == 3));
    @(negedge clk);
    checks++; if (controller_in_busy !== 1'b0) begin errors++; $display("FAIL push_pop_count got=%b want=0", controller_in_busy); end
    for (int j = 0; j < 4; j++) send_word(32'hB000_0000 + 32'(j), (j == 3), 1'b0);
    @(negedge clk);
    checks++; if (controller_in_busy !== 1'b1) begin errors++; $display("FAIL refill_busy got=%b want=1", controller_in_busy); end
    checks++; if (controller_in_done !== 1'b1) begin errors++; $display("FAIL full_done got=%b want=1", controller_in_done); end
    // Simultaneous word and pop at full: word ignored, pop succeeds
    send_word(32'hFFFF_0000, 1'b0, 1'b1);
    @(negedge clk);
    checks++; if (controller_in_busy !== 1'b0) begin errors++; $display("FAIL full_pop_busy got=%b want=0", controller_in_busy); end
    for (int k = 3; k < 256; k++) begin
      @(negedge clk);
      checks++;
      if (in_fifo_rdata !== fill_entry(k)) begin errors++; $display("FAIL drain_%0d got=%h want=%h", k, in_fifo_rdata, fill_entry(k)); end
      pop_one();
    end
    @(negedge clk);
    checks++; if (in_fifo_rdata !== exp_a) begin errors++; $display("FAIL drain_a got=%h want=%h", in_fifo_rdata, exp_a); end
    pop_one();
    @(negedge clk);
    checks++; if (in_fifo_rdata !== exp_b) begin errors++; $display("FAIL drain_b got=%h want=%h", in_fifo_rdata, exp_b); end
    pop_one();
    @(negedge clk);
    checks++; if (in_fifo_empty !== 1'b1) begin errors++; $display("FAIL full_drain_empty got=%b want=1", in_fifo_empty); end
  endtask

  task automatic test_reset_mid_packet();
    logic [128:0] exp;
    exp = {1'b1, 128'h00000001_00000002_00000003_00000004};
    send_word(32'h0000_0055, 1'b0, 1'b0);
    @(negedge clk);
    checks++; if (controller_in_done !== 1'b0) begin errors++; $display("FAIL second_cmd_done got=%b want=0", controller_in_done); end
    checks++; if (aes_cmd !== 32'h0000_0055) begin errors++; $display("FAIL second_cmd got=%h want=00000055", aes_cmd); end
    for (int i = 0; i < 6; i++) send_word(32'h5500_0000 + 32'(i), 1'b0, 1'b0);
    @(negedge clk);
    checks++; if (in_fifo_read_tvalid !== 1'b1) begin errors++; $display("FAIL pre_reset_tvalid got=%b want=1", in_fifo_read_tvalid); end
    apply_reset();
    @(negedge clk);
    checks++; if (in_fifo_empty !== 1'b1) begin errors++; $display("FAIL mid_reset_empty got=%b want=1", in_fifo_empty); end
    checks++; if (aes_cmd !== 32'h0) begin errors++; $display("FAIL mid_reset_cmd got=%h want=0", aes_cmd); end
    checks++; if (controller_in_done !== 1'b0) begin errors++; $display("FAIL mid_reset_done got=%b want=0", controller_in_done); end
    send_word(32'h0000_0099, 1'b0, 1'b0);
    @(negedge clk);
    checks++; if (aes_cmd !== 32'h0000_0099) begin errors++; $display("FAIL post_reset_cmd got=%h want=00000099", aes_cmd); end
    checks++; if (in_fifo_empty !== 1'b1) begin errors++; $display("FAIL post_reset_empty got=%b want=1", in_fifo_empty); end
    for (int i = 1; i <= 4; i++) send_word(32'(i), (i == 4), 1'b0);
    @(negedge clk);
    checks++; if (in_fifo_rdata !== exp) begin errors++; $display("FAIL post_reset_entry got=%h want=%h", in_fifo_rdata, exp); end
    pop_one();
    @(negedge clk);
    checks++; if (in_fifo_empty !== 1'b1) begin errors++; $display("FAIL post_reset_drain got=%b want=1", in_fifo_empty); end
  endtask

  initial begin
    reset               = 1'b1;
    bus_data_wren       = 1'b0;
    bus_tlast           = 1'b0;
    bus_data            = '0;
    in_fifo_read_tready = 1'b0;
    test_reset();
    test_single_block();
    test_back_to_back();
    test_partial_block();
    test_full();
    test_reset_mid_packet();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
